// File: rtl/div_pkg.sv
// Shared definitions for the signed-division shell: width-derived constants,
// two's-complement magnitude and the first-stage payload.
package div_pkg;

  localparam int unsigned DIV_DW = 16;
  localparam int unsigned DIV_VW = 16;

  typedef struct packed {
    logic [DIV_DW-1:0] mag_dividend;
    logic [DIV_VW-1:0] mag_divisor;
    logic              q_neg;
    logic              r_neg;
  } s1_payload_t;

  function automatic logic [63:0] width_mask(input int unsigned w);
    logic [63:0] m;
    if (w >= 32'd64) begin
      m = '1;
    end else begin
      m = (64'd1 << w) - 64'd1;
    end
    return m;
  endfunction

  function automatic logic [63:0] max_pos(input int unsigned w);
    return width_mask(w) >> 1;
  endfunction

  function automatic logic [63:0] min_neg(input int unsigned w);
    return 64'd1 << (w - 32'd1);
  endfunction

  // The most negative value maps to 2^(w-1), which still fits unsigned at width w.
  function automatic logic [63:0] magnitude(input logic [63:0] x, input int unsigned w);
    logic [63:0] r;
    if (((x >> (w - 32'd1)) & 64'd1) != 64'd0) begin
      r = (~x + 64'd1) & width_mask(w);
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Second-stage input logic: turns the unsigned core result back into a signed
// quotient/remainder, applying divide-by-zero and MIN/-1 saturation.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIV_DW,
  parameter int unsigned DIVISOR_WIDTH  = DIV_VW
) (
  input  logic [DIVIDEND_WIDTH-1:0] core_quotient,
  input  logic [DIVISOR_WIDTH-1:0]  core_remainder,
  input  logic                      core_overflow,
  input  logic                      q_neg,
  input  logic                      r_neg,
  output logic [DIVIDEND_WIDTH-1:0] fix_quotient,
  output logic [DIVISOR_WIDTH-1:0]  fix_remainder,
  output logic                      fix_div_by_zero,
  output logic                      fix_overflow
);

  localparam logic [DIVIDEND_WIDTH-1:0] MAX_POS = DIVIDEND_WIDTH'(max_pos(DIVIDEND_WIDTH));
  localparam logic [DIVIDEND_WIDTH-1:0] MIN_NEG = DIVIDEND_WIDTH'(min_neg(DIVIDEND_WIDTH));

  // r_neg is the dividend sign, which also picks the divide-by-zero saturation direction.
  always_comb begin
    fix_quotient    = '0;
    fix_remainder   = '0;
    fix_div_by_zero = 1'b0;
    fix_overflow    = 1'b0;
    if (core_overflow) begin
      fix_div_by_zero = 1'b1;
      fix_quotient    = r_neg ? MIN_NEG : MAX_POS;
    end else if (!q_neg && core_quotient[DIVIDEND_WIDTH-1]) begin
      fix_overflow = 1'b1;
      fix_quotient = MAX_POS;
    end else begin
      fix_quotient  = q_neg ? -core_quotient : core_quotient;
      fix_remainder = r_neg ? -core_remainder : core_remainder;
    end
  end

endmodule

// File: rtl/div_signed_stage.sv
// Two-stage signed-division shell around an external unsigned divider core,
// with valid/ready on both the operand and the result side.
module div_signed_stage
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIV_DW,
  parameter int unsigned DIVISOR_WIDTH  = DIV_VW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
  output logic                      core_start,
  output logic [DIVIDEND_WIDTH-1:0] core_dividend,
  output logic [DIVISOR_WIDTH-1:0]  core_divisor,
  input  logic [DIVIDEND_WIDTH-1:0] core_quotient,
  input  logic [DIVISOR_WIDTH-1:0]  core_remainder,
  input  logic                      core_overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] out_quotient,
  output logic [DIVISOR_WIDTH-1:0]  out_remainder,
  output logic                      out_div_by_zero,
  output logic                      out_overflow
);

  s1_payload_t               s1_q, s1_d;
  logic                      s1_valid_q, s1_valid_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [DIVIDEND_WIDTH-1:0] s2_quotient_q, s2_quotient_d;
  logic [DIVISOR_WIDTH-1:0]  s2_remainder_q, s2_remainder_d;
  logic                      s2_dbz_q, s2_dbz_d;
  logic                      s2_ovf_q, s2_ovf_d;

  logic                      s1_adv, accept, retire;
  logic [DIVIDEND_WIDTH-1:0] fix_quotient;
  logic [DIVISOR_WIDTH-1:0]  fix_remainder;
  logic                      fix_div_by_zero, fix_overflow;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready;

  assign core_start      = s1_valid_q;
  assign core_dividend   = s1_q.mag_dividend;
  assign core_divisor    = s1_q.mag_divisor;
  assign out_valid       = s2_valid_q;
  assign out_quotient    = s2_quotient_q;
  assign out_remainder   = s2_remainder_q;
  assign out_div_by_zero = s2_dbz_q;
  assign out_overflow    = s2_ovf_q;

  div_sign_fix #(
    .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_sign_fix (
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .core_overflow  (core_overflow),
    .q_neg          (s1_q.q_neg),
    .r_neg          (s1_q.r_neg),
    .fix_quotient   (fix_quotient),
    .fix_remainder  (fix_remainder),
    .fix_div_by_zero(fix_div_by_zero),
    .fix_overflow   (fix_overflow)
  );

  // Stage 1 next state: capture magnitudes and signs on accept, empty on advance.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d      = 1'b1;
      s1_d.mag_dividend = DIVIDEND_WIDTH'(magnitude(64'(in_dividend), DIVIDEND_WIDTH));
      s1_d.mag_divisor  = DIVISOR_WIDTH'(magnitude(64'(in_divisor), DIVISOR_WIDTH));
      s1_d.q_neg      = in_dividend[DIVIDEND_WIDTH-1] ^ in_divisor[DIVISOR_WIDTH-1];
      s1_d.r_neg      = in_dividend[DIVIDEND_WIDTH-1];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: reload from the core whenever stage 1 advances, else drain on retire.
  always_comb begin
    s2_valid_d     = s2_valid_q;
    s2_quotient_d  = s2_quotient_q;
    s2_remainder_d = s2_remainder_q;
    s2_dbz_d       = s2_dbz_q;
    s2_ovf_d       = s2_ovf_q;
    if (s1_adv) begin
      s2_valid_d     = 1'b1;
      s2_quotient_d  = fix_quotient;
      s2_remainder_d = fix_remainder;
      s2_dbz_d       = fix_div_by_zero;
      s2_ovf_d       = fix_overflow;
    end else if (retire) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= '0;
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_quotient_q  <= '0;
      s2_remainder_q <= '0;
      s2_dbz_q       <= 1'b0;
      s2_ovf_q       <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s1_valid_q     <= s1_valid_d;
      s2_valid_q     <= s2_valid_d;
      s2_quotient_q  <= s2_quotient_d;
      s2_remainder_q <= s2_remainder_d;
      s2_dbz_q       <= s2_dbz_d;
      s2_ovf_q       <= s2_ovf_d;
    end
  end

endmodule

// File: doc/div_signed_stage.md
# div_signed_stage

Pipelined signed-division shell for the demodulator datapath. It accepts two's-complement operands over a valid/ready handshake and converts them to magnitudes for the combinational unsigned `divider` core, which it drives through a dedicated core-side port group. It consumes the core's unsigned quotient, remainder and divide-by-zero flag, restores signs, saturates unrepresentable results and presents them downstream on a second valid/ready interface. The core is instantiated beside this block at the parent level.

## Interface
- `DIVIDEND_WIDTH`, 16, signed dividend and quotient width (≥2).
- `DIVISOR_WIDTH`, 16, signed divisor and remainder width (≥2).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept operands this cycle.
- `in_dividend`  in  DIVIDEND_WIDTH  signed dividend.
- `in_divisor`  in  DIVISOR_WIDTH  signed divisor.
- `core_start`  out  1  to core `start`; equals S1 valid.
- `core_dividend`  out  DIVIDEND_WIDTH  unsigned |dividend|, registered.
- `core_divisor`  out  DIVISOR_WIDTH  unsigned |divisor|, registered.
- `core_quotient`  in  DIVIDEND_WIDTH  unsigned quotient from core.
- `core_remainder`  in  DIVISOR_WIDTH  unsigned remainder from core.
- `core_overflow`  in  1  core divide-by-zero flag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts result.
- `out_quotient`  out  DIVIDEND_WIDTH  signed quotient.
- `out_remainder`  out  DIVISOR_WIDTH  signed remainder.
- `out_div_by_zero`  out  1  divisor was 0.
- `out_overflow`  out  1  quotient saturated (MIN/−1).

## Operation
- Two register stages. S1 holds magnitudes, `q_neg = sd ^ sv` and `r_neg = sd`, where `sd` and `sv` are the operand sign bits. S2 holds the final signed result and flags.
- Magnitude is `x[MSB] ? -x : x`, taken as unsigned at the same width. MIN maps to 2^(W−1) exactly.
- Division truncates toward zero. The remainder takes the dividend's sign. An S2 update applies the following rules in priority order:
  1. `core_overflow` = 1 (divisor 0): `out_div_by_zero`=1. `out_quotient` = MAX_POS if dividend ≥ 0, otherwise MIN_NEG. `out_remainder` = 0.
  2. `!q_neg && core_quotient[MSB]` (only MIN/−1): `out_overflow`=1, `out_quotient` = MAX_POS, `out_remainder` = 0.
  3. Otherwise: `out_quotient` = q_neg ? −core_quotient : core_quotient, and `out_remainder` = r_neg ? −core_remainder : core_remainder. Both flags are 0.
- Core outputs are sampled only when S1 is valid and advancing.
- Handshake:
  - `s1_adv = s1_valid && (!s2_valid || out_ready)`.
  - `in_ready = !s1_valid || s1_adv` (combinational; no dependency on `in_valid`).
  - An input is accepted when `in_valid && in_ready`.
- An S2 result retires when `out_valid && out_ready`. If S1 advances in the same cycle, S2 reloads. If not, `s2_valid` clears.
- Outputs hold stable while `out_valid && !out_ready`. Results are never dropped, duplicated or reordered.

## Timing
- Latency: an input accepted on edge N produces `out_valid` after edge N+1, provided no stall occurs.
- Throughput is one result per cycle with `out_ready` held high.
- With `out_ready` low, at most 2 results are buffered. `in_ready` falls in the cycle both stages are full.
- Simultaneous accept, advance and retire in one cycle are all legal. Pipeline occupancy remains unchanged.
- Reset drives both valids to 0 and all data and flag registers to 0. Outputs during reset: `core_start`=0, `out_valid`=0, `out_div_by_zero`=0, `out_overflow`=0, `in_ready`=1.
- Reset asserted mid-stream discards all in-flight items. The first input after release behaves as from idle.

## Structure
- Shared package `div_pkg`:
  - MAX_POS/MIN_NEG constant functions of width.
  - The magnitude function.
  - The S1 payload struct: magnitudes, `q_neg`, `r_neg`.
- Sub-module `div_sign_fix`: combinational S2-input logic (the three-way priority, negation, saturation). It is instantiated once; the registers stay in `div_signed_stage`.
- The bench pairs this block with the unsigned `divider` core at matching widths.

## Test plan
- 16/16 widths, −7 / 2 → quotient −3, remainder −1. Also 7 / −2 → quotient −3, remainder 1. Both flags 0, result 2 cycles after accept.
- −32768 / −1 → quotient 32767, remainder 0, `out_overflow`=1. Also −32768 / 1 → quotient −32768, overflow 0.
- 100 / 0 → quotient 32767, remainder 0, `out_div_by_zero`=1. Also −100 / 0 → quotient −32768.
- Back-to-back stream of 8 random pairs with `out_ready`=1 → 8 consecutive results matching the reference model in order, one per cycle.
- Hold `out_ready`=0 for 5 cycles while presenting 3 pairs → exactly 2 accepted, `in_ready` low until `out_ready` rises, outputs stable, no loss.
- Assert `rst_n` low with 2 items in flight → `out_valid` 0 immediately (asynchronous), no stale output after release, next input correct.
